pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised fetch-stage program counter and next-PC selector.
- Holds the PC of the instruction currently being fetched, and picks the next PC from: sequential, branch, jump, or a return-address stack (RAS) pop.
- Advances only on debug step and when not stalled by the hazard unit.
- Includes a halt state machine for end-of-program detection.

Parameters:
- NB, 32, PC/address width in bits.
- RESET_PC, 0, PC value loaded on reset and on redirect-to-start.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_step  in  1  debug step enable; PC may advance only when high.
- i_pc_write  in  1  hazard-unit write enable; low = stall.
- i_branch_taken  in  1  branch resolved taken.
- i_branch_target  in  NB  branch destination.
- i_jump  in  1  unconditional jump.
- i_jump_target  in  NB  jump destination; also the fallback for a return on RAS underflow.
- i_call  in  1  with i_jump: push return address.
- i_return  in  1  with i_jump: pop RAS as target.
- i_halt  in  1  halt instruction fetched.
- i_resume  in  1  leave HALTED state.
- o_pc  out  NB  current PC.
- o_pc_seq  out  NB  o_pc + INC (combinational, modulo 2^NB).
- o_halted  out  1  high in HALTED.
- o_ras_empty  out  1  RAS count == 0.
- o_ras_full  out  1  RAS count == RAS_DEPTH.
- o_ras_underflow  out  1  one-cycle pulse, return popped while empty.

Behaviour:
- **Reset (async, any time, including mid-halt):**
  - o_pc = RESET_PC; state RUN; RAS count = 0; o_halted = 0; o_ras_underflow = 0.
  - RAS entry contents are don't-care.
- **Advance condition:** adv = i_step & i_pc_write & (state == RUN). When adv is low: PC, RAS and state hold, and o_ras_underflow = 0.
- **Next-PC priority when adv (one cycle latency, registered on the rising edge):**
  1. i_branch_taken → i_branch_target.
  2. i_jump & i_return → RAS top if count > 0; otherwise i_jump_target, with o_ras_underflow = 1 for one cycle.
  3. i_jump → i_jump_target.
  4. Otherwise → o_pc + INC.
- **Arithmetic:** all arithmetic is modulo 2^NB; o_pc + INC wraps to low values without error.
- **RAS push:** on adv & i_jump & i_call & ~i_branch_taken, push o_pc + INC.
  - Full: overwrite the oldest entry (circular write pointer); count saturates at RAS_DEPTH.
- **RAS pop:** on adv & i_jump & i_return & ~i_branch_taken & count > 0, pop; count decrements.
- **Call and return together:** the target is the popped top, then the new return address replaces the top; count is unchanged.
  - If the stack is empty: fallback target, underflow pulse, push the new address, count becomes 1.
- **Branch override:** a taken branch suppresses all RAS activity in that cycle.
- **State machine:**
  - RUN → HALTED on adv & i_halt. That same edge still performs the normal next-PC update.
  - HALTED: PC and RAS frozen regardless of other inputs; o_halted = 1.
  - HALTED → RUN on i_resume & i_step; PC is not modified on that edge.
  - i_halt is ignored while HALTED.
- **Timing:** outputs are registered except o_pc_seq, o_ras_empty and o_ras_full, which are combinational from registers.
- **Size:** target implementation is 150–250 lines of RTL.

Test Plan:
1. **Reset and sequential step.** Assert i_reset_n = 0 asynchronously mid-cycle, release, then hold i_step = 1 and i_pc_write = 1 for 3 cycles.
   → o_pc changes to 0 immediately on reset, then reads 0x0, 0x4, 0x8, 0xC; o_pc_seq = 0x10 at the end.
2. **Stall and step gating.** With PC = 0x8, pulse i_pc_write = 0 for 2 cycles, then i_step = 0 for 2 cycles.
   → o_pc holds 0x8 for all 4 cycles, then advances to 0xC.
3. **Priority.** At PC = 0x20, assert i_branch_taken (target 0x100) together with i_jump + i_call (target 0x200).
   → o_pc = 0x100; RAS count stays 0; o_ras_empty = 1.
4. **Call/return with overflow.** RAS_DEPTH = 4. Perform 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50, then 5 returns.
   → Return targets are 0x54, 0x44, 0x34, 0x24, then the fallback i_jump_target with o_ras_underflow pulsing exactly one cycle.
   → o_ras_full = 1 after the 4th call.
5. **Halt/resume.** Assert i_halt at PC = 0x30 with adv.
   → o_pc = 0x34, o_halted = 1; o_pc stays 0x34 for 10 cycles despite i_jump.
   → i_resume + i_step returns to RUN with o_pc = 0x34, and the next step gives 0x38.
6. **Wrap and reset mid-halt.** NB = 8, PC = 0xFC, step once → o_pc = 0x00. Enter HALTED, then assert reset.
   → o_halted = 0, o_pc = RESET_PC, RAS empty.

Source files
------------

// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
// Bundles the fetch-stage control inputs and the program-counter status
// outputs of pc_unit into one interface. Clock and reset stay outside.
//
// Signals (direction as seen by pc_unit through the slave modport):
//   i_step           in   debug step enable
//   i_pc_write       in   hazard-unit write enable, low = stall
//   i_branch_taken   in   branch resolved taken
//   i_branch_target  in   branch destination
//   i_jump           in   unconditional jump
//   i_jump_target    in   jump destination / fallback on RAS underflow
//   i_call           in   with i_jump: push return address
//   i_return         in   with i_jump: pop return address
//   i_halt           in   halt instruction fetched
//   i_resume         in   leave the halted state
//   o_pc             out  current PC
//   o_pc_seq         out  o_pc + INC
//   o_halted         out  high while halted
//   o_ras_empty      out  return stack holds no entries
//   o_ras_full       out  return stack holds RAS_DEPTH entries
//   o_ras_underflow  out  one-cycle pulse, return popped while empty
// ---------------------------------------------------------------------------
interface pc_unit_if #(
    parameter int NB = 32
);
    logic          i_step;
    logic          i_pc_write;
    logic          i_branch_taken;
    logic [NB-1:0] i_branch_target;
    logic          i_jump;
    logic [NB-1:0] i_jump_target;
    logic          i_call;
    logic          i_return;
    logic          i_halt;
    logic          i_resume;
    logic [NB-1:0] o_pc;
    logic [NB-1:0] o_pc_seq;
    logic          o_halted;
    logic          o_ras_empty;
    logic          o_ras_full;
    logic          o_ras_underflow;

    // Driver side: the pipeline / hazard unit / debug controller
    modport master (
        output i_step, i_pc_write, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_call, i_return, i_halt, i_resume,
        input  o_pc, o_pc_seq, o_halted, o_ras_empty, o_ras_full,
               o_ras_underflow
    );

    // Program counter side
    modport slave (
        input  i_step, i_pc_write, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_call, i_return, i_halt, i_resume,
        output o_pc, o_pc_seq, o_halted, o_ras_empty, o_ras_full,
               o_ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Fetch-stage program counter with next-PC selection (sequential, branch,
// jump, return-address-stack pop) and a RUN/HALTED state machine.
//
// Ports:
//   i_clk      in   clock, rising edge
//   i_reset_n  in   asynchronous active-low reset
//   bus        slave modport of pc_unit_if (control inputs, PC/RAS status)
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int            NB        = 32,
    parameter logic [NB-1:0] RESET_PC  = '0,
    parameter int            INC       = 4,
    parameter int            RAS_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    pc_unit_if.slave    bus
);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [NB-1:0] INC_V      = NB'(INC);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   COUNT_FULL = (PW+1)'(RAS_DEPTH);

    typedef enum logic {
        RUN,
        HALTED
    } pcState_t;

    pcState_t      state_q, state_d;
    logic [NB-1:0] pc_q, pc_d;
    logic [PW-1:0] rasPtr_q, rasPtr_d;
    logic [PW:0]   rasCount_q, rasCount_d;
    logic          underflow_q, underflow_d;
    logic [NB-1:0] ras_q [RAS_DEPTH];

    logic          adv;
    logic          doCall;
    logic          doReturn;
    logic          rasEmpty;
    logic          rasFull;
    logic [PW-1:0] topIdx;
    logic [NB-1:0] pcSeq;
    logic          rasWe;
    logic [PW-1:0] rasWaddr;

    assign pcSeq    = pc_q + INC_V;
    assign rasEmpty = (rasCount_q == '0);
    assign rasFull  = (rasCount_q == COUNT_FULL);
    // rasPtr_q is the next free slot, so the top of stack sits just below it
    assign topIdx   = rasPtr_q - PTR_ONE;

    assign adv      = bus.i_step & bus.i_pc_write & (state_q == RUN);
    // A taken branch suppresses every stack operation in the same cycle
    assign doCall   = adv & bus.i_jump & bus.i_call   & ~bus.i_branch_taken;
    assign doReturn = adv & bus.i_jump & bus.i_return & ~bus.i_branch_taken;

    // Next-PC selection, stack bookkeeping and halt state machine.
    // Everything holds unless adv is high (or, in HALTED, a resume step).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rasPtr_d    = rasPtr_q;
        rasCount_d  = rasCount_q;
        underflow_d = 1'b0;
        rasWe       = 1'b0;
        rasWaddr    = rasPtr_q;

        if (adv) begin
            if (bus.i_branch_taken) begin
                pc_d = bus.i_branch_target;
            end else if (bus.i_jump && bus.i_return) begin
                if (rasEmpty) begin
                    pc_d        = bus.i_jump_target;
                    underflow_d = 1'b1;
                end else begin
                    pc_d = ras_q[topIdx];
                end
            end else if (bus.i_jump) begin
                pc_d = bus.i_jump_target;
            end else begin
                pc_d = pcSeq;
            end
        end

        // Call+return on a non-empty stack swaps the top in place; on an
        // empty stack it degenerates to a plain push.
        if (doCall && doReturn && !rasEmpty) begin
            rasWe    = 1'b1;
            rasWaddr = topIdx;
        end else if (doCall) begin
            // When full the write slot holds the oldest entry, so it is
            // overwritten and the count saturates
            rasWe    = 1'b1;
            rasWaddr = rasPtr_q;
            rasPtr_d = rasPtr_q + PTR_ONE;
            if (!rasFull) begin
                rasCount_d = rasCount_q + COUNT_ONE;
            end
        end else if (doReturn && !rasEmpty) begin
            rasPtr_d   = topIdx;
            rasCount_d = rasCount_q - COUNT_ONE;
        end

        case (state_q)
            RUN: begin
                if (adv && bus.i_halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (bus.i_resume && bus.i_step) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control registers; reset returns to RUN at RESET_PC with an empty stack
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            rasPtr_q    <= '0;
            rasCount_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rasPtr_q    <= rasPtr_d;
            rasCount_q  <= rasCount_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack storage carries no reset; validity is tracked by rasCount_q
    always_ff @(posedge i_clk) begin
        if (rasWe) begin
            ras_q[rasWaddr] <= pcSeq;
        end
    end

    assign bus.o_pc            = pc_q;
    assign bus.o_pc_seq        = pcSeq;
    assign bus.o_halted        = (state_q == HALTED);
    assign bus.o_ras_empty     = rasEmpty;
    assign bus.o_ras_full      = rasFull;
    assign bus.o_ras_underflow = underflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Directed test of pc_unit: sequential stepping, stall/step gating, branch
// priority over call, call/return through RAS overflow and underflow,
// combined call+return, halt/resume, address wrap and reset while halted.
// ---------------------------------------------------------------------------
module tb_pc_unit;
    logic clk;
    logic resetN;
    int   checkCount;
    int   failCount;

    pc_unit_if #(.NB(32)) bus ();

    pc_unit #(
        .NB        (32),
        .RESET_PC  (32'h0),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (resetN),
        .bus       (bus.slave)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle just after the edge
    task automatic applyStimulus(input logic step, input logic pcWrite,
                                 input logic branch, input logic [31:0] brTarget,
                                 input logic jump, input logic [31:0] jTarget,
                                 input logic call, input logic ret,
                                 input logic halt, input logic resume);
        bus.i_step          = step;
        bus.i_pc_write      = pcWrite;
        bus.i_branch_taken  = branch;
        bus.i_branch_target = brTarget;
        bus.i_jump          = jump;
        bus.i_jump_target   = jTarget;
        bus.i_call          = call;
        bus.i_return        = ret;
        bus.i_halt          = halt;
        bus.i_resume        = resume;
        @(posedge clk);
        #1;
    endtask

    task automatic stepSeq();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doJump(input logic [31:0] t);
        applyStimulus(1, 1, 0, 0, 1, t, 0, 0, 0, 0);
    endtask

    task automatic doCall(input logic [31:0] t);
        applyStimulus(1, 1, 0, 0, 1, t, 1, 0, 0, 0);
    endtask

    task automatic doReturn(input logic [31:0] t);
        applyStimulus(1, 1, 0, 0, 1, t, 0, 1, 0, 0);
    endtask

    task automatic doCallReturn(input logic [31:0] t);
        applyStimulus(1, 1, 0, 0, 1, t, 1, 1, 0, 0);
    endtask

    initial begin
        logic [31:0] retExp [4];
        checkCount = 0;
        failCount  = 0;
        resetN     = 1'b0;
        bus.i_step = 0; bus.i_pc_write = 0; bus.i_branch_taken = 0;
        bus.i_branch_target = 0; bus.i_jump = 0; bus.i_jump_target = 0;
        bus.i_call = 0; bus.i_return = 0; bus.i_halt = 0; bus.i_resume = 0;

        // Reset and sequential stepping
        repeat (2) @(posedge clk);
        #3;
        resetN = 1'b1;
        #1;
        checkOutput("reset_pc", bus.o_pc, 32'h0);
        checkOutput("reset_halted", 32'(bus.o_halted), 32'h0);
        checkOutput("reset_empty", 32'(bus.o_ras_empty), 32'h1);
        checkOutput("reset_full", 32'(bus.o_ras_full), 32'h0);
        checkOutput("reset_uflow", 32'(bus.o_ras_underflow), 32'h0);
        stepSeq(); checkOutput("seq1", bus.o_pc, 32'h4);
        stepSeq(); checkOutput("seq2", bus.o_pc, 32'h8);
        stepSeq(); checkOutput("seq3", bus.o_pc, 32'hC);
        checkOutput("seq_pcseq", bus.o_pc_seq, 32'h10);

        // Stall and step gating
        doJump(32'h8); checkOutput("jump_to_8", bus.o_pc, 32'h8);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("stall1", bus.o_pc, 32'h8);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("stall2", bus.o_pc, 32'h8);
        idle(); checkOutput("nostep1", bus.o_pc, 32'h8);
        idle(); checkOutput("nostep2", bus.o_pc, 32'h8);
        stepSeq(); checkOutput("after_gate", bus.o_pc, 32'hC);

        // Taken branch beats jump+call and blocks the push
        doJump(32'h20); checkOutput("jump_to_20", bus.o_pc, 32'h20);
        applyStimulus(1, 1, 1, 32'h100, 1, 32'h200, 1, 0, 0, 0);
        checkOutput("prio_pc", bus.o_pc, 32'h100);
        checkOutput("prio_empty", 32'(bus.o_ras_empty), 32'h1);

        // Five calls into a four-deep stack, then five returns
        doJump(32'h10);
        for (int i = 1; i <= 5; i++) begin
            doCall(32'(i * 16 + 16));
            checkOutput($sformatf("call%0d_pc", i), bus.o_pc, 32'(i * 16 + 16));
            checkOutput($sformatf("call%0d_full", i), 32'(bus.o_ras_full),
                        (i >= 4) ? 32'h1 : 32'h0);
        end
        retExp[0] = 32'h54; retExp[1] = 32'h44; retExp[2] = 32'h34; retExp[3] = 32'h24;
        for (int i = 0; i < 4; i++) begin
            doReturn(32'h300);
            checkOutput($sformatf("ret%0d_pc", i), bus.o_pc, retExp[i]);
            checkOutput($sformatf("ret%0d_uflow", i), 32'(bus.o_ras_underflow), 32'h0);
        end
        checkOutput("ret_empty", 32'(bus.o_ras_empty), 32'h1);
        doReturn(32'h300);
        checkOutput("uflow_pc", bus.o_pc, 32'h300);
        checkOutput("uflow_pulse", 32'(bus.o_ras_underflow), 32'h1);
        idle();
        checkOutput("uflow_clear", 32'(bus.o_ras_underflow), 32'h0);

        // Call+return together: empty stack falls back and pushes, then swaps top
        doCallReturn(32'h400);
        checkOutput("cr_empty_pc", bus.o_pc, 32'h400);
        checkOutput("cr_empty_uflow", 32'(bus.o_ras_underflow), 32'h1);
        checkOutput("cr_empty_cnt", 32'(bus.o_ras_empty), 32'h0);
        doCallReturn(32'h500);
        checkOutput("cr_swap_pc", bus.o_pc, 32'h304);
        checkOutput("cr_swap_uflow", 32'(bus.o_ras_underflow), 32'h0);
        doReturn(32'h600);
        checkOutput("cr_pop_pc", bus.o_pc, 32'h404);
        checkOutput("cr_pop_empty", 32'(bus.o_ras_empty), 32'h1);

        // Halt and resume
        doJump(32'h30);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("halt_pc", bus.o_pc, 32'h34);
        checkOutput("halt_flag", 32'(bus.o_halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 0, 1, 32'h999, 1, 0, 1, 0);
            checkOutput($sformatf("halted%0d_pc", i), bus.o_pc, 32'h34);
        end
        checkOutput("halted_empty", 32'(bus.o_ras_empty), 32'h1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("resume_pc", bus.o_pc, 32'h34);
        checkOutput("resume_flag", 32'(bus.o_halted), 32'h0);
        stepSeq(); checkOutput("resume_step", bus.o_pc, 32'h38);

        // Address wrap, then reset while halted
        doJump(32'hFFFF_FFF8);
        doCall(32'hFFFF_FFFC);
        checkOutput("wrap_pre", bus.o_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pcseq", bus.o_pc_seq, 32'h0);
        stepSeq(); checkOutput("wrap_pc", bus.o_pc, 32'h0);
        checkOutput("wrap_nonempty", 32'(bus.o_ras_empty), 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("halt2_flag", 32'(bus.o_halted), 32'h1);
        checkOutput("halt2_pc", bus.o_pc, 32'h4);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("rst_halt_pc", bus.o_pc, 32'h0);
        checkOutput("rst_halt_flag", 32'(bus.o_halted), 32'h0);
        checkOutput("rst_halt_empty", 32'(bus.o_ras_empty), 32'h1);
        @(negedge clk);
        resetN = 1'b1;
        stepSeq(); checkOutput("post_rst_step", bus.o_pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
